// File: rtl/tpu_pkg.sv
// Shared types and constants for the TPU datapath blocks.
// Words are Q8.8 signed fixed point; the feeder only moves them around.
package tpu_pkg;

  localparam int DATA_W = 16;
  localparam int FRAC_W = 8;

  typedef logic signed [DATA_W-1:0] fixed_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    STREAM,
    DRAIN,
    DONE
  } feeder_state_t;

endpackage

// File: rtl/skew_delay.sv
// One-stage skew register: passes d_i one cycle later when valid_i is set,
// and drives zero otherwise so the array sees clean idle cycles.
module skew_delay
  import tpu_pkg::*;
#(
  parameter int W = DATA_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         valid_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= valid_i ? d_i : '0;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/systolic_feeder.sv
// Upstream feeder for the 2x2 systolic array: loads weights, then streams
// buffered input rows with a one-cycle skew on the second array row.
module systolic_feeder
  import tpu_pkg::*;
#(
  parameter int MAX_ROWS     = 8,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic                          wr_sel,
  input  logic [$clog2(2*MAX_ROWS)-1:0] wr_addr,
  input  logic [DATA_W-1:0]             wr_data,
  input  logic [$clog2(MAX_ROWS+1)-1:0] num_rows,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic                          sys_accept_w_1,
  output logic                          sys_accept_w_2,
  output logic                          sys_switch_in,
  output logic [DATA_W-1:0]             sys_weight_in_11,
  output logic [DATA_W-1:0]             sys_weight_in_12,
  output logic [DATA_W-1:0]             sys_data_in_11,
  output logic [DATA_W-1:0]             sys_data_in_21
);

  localparam int AW    = $clog2(2*MAX_ROWS);
  localparam int NW    = $clog2(MAX_ROWS+1);
  localparam int CMAX  = (MAX_ROWS > DRAIN_CYCLES) ? MAX_ROWS : DRAIN_CYCLES;
  localparam int CNT_W = $clog2(CMAX+1);

  feeder_state_t    state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] n_q;
  logic             busy_q;
  logic             done_q;
  logic             acc1_q;
  logic             acc2_q;
  logic             sw_q;
  fixed_t           w11_q;
  fixed_t           d11_q;

  fixed_t wmem_q [4];
  fixed_t wmem_d [4];
  fixed_t xmem_q [2*MAX_ROWS];
  fixed_t xmem_d [2*MAX_ROWS];

  logic [NW-1:0]    n_clamp;
  logic [CNT_W-1:0] nxt_k;
  logic [AW-1:0]    x_nxt0;
  logic [AW-1:0]    x_cur1;
  logic             w2_vld;
  logic             d2_vld;
  fixed_t           w2_d;
  fixed_t           d2_d;

  // Memories are only writable in IDLE; the _d view forwards a write
  // made in the same cycle as start into the first loaded words.
  always_comb begin
    wmem_d = wmem_q;
    xmem_d = xmem_q;
    if (wr_en && state_q == IDLE) begin
      if (!wr_sel) begin
        if (wr_addr < AW'(4)) wmem_d[wr_addr[1:0]] = wr_data;
      end else begin
        xmem_d[wr_addr] = wr_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) wmem_q[i] <= '0;
      for (int i = 0; i < 2*MAX_ROWS; i++) xmem_q[i] <= '0;
    end else begin
      wmem_q <= wmem_d;
      xmem_q <= xmem_d;
    end
  end

  assign n_clamp = (num_rows > NW'(MAX_ROWS)) ? NW'(MAX_ROWS) : num_rows;
  assign nxt_k   = cnt_q + 1'b1;
  assign x_nxt0  = AW'({nxt_k, 1'b0});
  assign x_cur1  = AW'({cnt_q, 1'b1});

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      n_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      acc1_q  <= 1'b0;
      acc2_q  <= 1'b0;
      sw_q    <= 1'b0;
      w11_q   <= '0;
      d11_q   <= '0;
    end else begin
      done_q <= 1'b0;
      acc1_q <= 1'b0;
      acc2_q <= (state_q == LOAD);
      sw_q   <= 1'b0;
      w11_q  <= '0;
      d11_q  <= '0;
      unique case (state_q)
        IDLE: begin
          busy_q <= 1'b0;
          if (start && num_rows != '0) begin
            state_q <= LOAD;
            cnt_q   <= '0;
            n_q     <= CNT_W'(n_clamp);
            busy_q  <= 1'b1;
            acc1_q  <= 1'b1;
            w11_q   <= wmem_d[2];
          end
        end
        LOAD: begin
          if (cnt_q == '0) begin
            cnt_q  <= 1'b1;
            acc1_q <= 1'b1;
            w11_q  <= wmem_d[0];
          end else begin
            state_q <= STREAM;
            cnt_q   <= '0;
            sw_q    <= 1'b1;
            d11_q   <= xmem_d[0];
          end
        end
        STREAM: begin
          if (cnt_q == n_q) begin
            cnt_q <= '0;
            if (DRAIN_CYCLES == 0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              state_q <= DRAIN;
            end
          end else begin
            cnt_q <= nxt_k;
            if (nxt_k < n_q) d11_q <= xmem_d[x_nxt0];
          end
        end
        DRAIN: begin
          if (cnt_q == CNT_W'(DRAIN_CYCLES - 1)) begin
            state_q <= DONE;
            cnt_q   <= '0;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= nxt_k;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Column-2 weights and row-2 activations trail their partners by a cycle.
  assign w2_vld = (state_q == LOAD);
  assign w2_d   = (cnt_q == '0) ? wmem_q[3] : wmem_q[1];
  assign d2_vld = (state_q == STREAM) && (cnt_q < n_q);
  assign d2_d   = xmem_q[x_cur1];

  skew_delay #(.W(DATA_W)) u_wskew (
    .clk     (clk),
    .rst_n   (rst),
    .valid_i (w2_vld),
    .d_i     (w2_d),
    .q_o     (sys_weight_in_12)
  );

  skew_delay #(.W(DATA_W)) u_dskew (
    .clk     (clk),
    .rst_n   (rst),
    .valid_i (d2_vld),
    .d_i     (d2_d),
    .q_o     (sys_data_in_21)
  );

  assign busy             = busy_q;
  assign done             = done_q;
  assign sys_accept_w_1   = acc1_q;
  assign sys_accept_w_2   = acc2_q;
  assign sys_switch_in    = sw_q;
  assign sys_weight_in_11 = w11_q;
  assign sys_data_in_11   = d11_q;

endmodule
